mem_scan_ctrl: RTL and testbench
================================

MEM_SCAN_CTRL -- requirements
Module: mem_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, giving clock cycles each digit stays lit (minimum 2).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15, giving the maximum cycles waited for mem_ack (minimum 1).
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port addr_a  in  4  word address chosen by the user switches.
REQ-006 SHALL have port mem_addr  out  4  read address to the memory/register file.
REQ-007 SHALL have port mem_rd  out  1  read request, held until acknowledged or timed out.
REQ-008 SHALL have port mem_ack  in  1  one-cycle read-data-valid strobe from the memory.
REQ-009 SHALL have port mem_rdata  in  16  read data, valid when mem_ack=1.
REQ-010 SHALL have port sel  out  4  digit enables, active-low, one-hot-zero.
REQ-011 SHALL have port data  out  8  segment pattern, active-low; bit7 is the decimal point, bits6:0 are g..a.
REQ-012 SHALL have port err  out  1  high while the displayed word comes from a timed-out read.

Function
REQ-013 FSM states SHALL be IDLE, REQ and SHOW; reset enters REQ.
REQ-014 On entering REQ, addr_a SHALL be latched into addr_q; mem_addr SHALL equal addr_q and mem_rd SHALL be 1 in every REQ cycle.
REQ-015 In REQ, mem_ack=1 SHALL latch mem_rdata into word_q, clear err, and move to SHOW the next cycle.
REQ-016 In REQ, after ACK_TIMEOUT cycles without mem_ack, word_q SHALL load 16'hEEEE, err SHALL set, and the FSM SHALL move to SHOW.
REQ-017 mem_ack arriving in the same cycle as the timeout SHALL take priority: data is latched and err stays 0.
REQ-018 mem_ack outside REQ SHALL be ignored.
REQ-019 In SHOW or IDLE, addr_a != addr_q SHALL enter REQ next cycle.
REQ-020 A change of addr_a during REQ SHALL NOT abort the read; the mismatch SHALL trigger a new REQ after SHOW.
REQ-021 At the end of each full frame (digit 3 to digit 0 wrap), the FSM SHALL enter REQ to refresh word_q even if the address is unchanged.
REQ-022 SHOW SHALL fall to IDLE after one cycle; IDLE and SHOW differ only in the FSM code, not in outputs.
REQ-023 A divider SHALL count 0..SCAN_DIV-1 continuously in all states; on wrap, digit index idx SHALL advance 0,1,2,3,0.
REQ-024 sel SHALL be registered: sel = ~(4'b0001 << idx).
REQ-025 data SHALL show nibble word_q[4*idx+3:4*idx], hex-decoded 0-F, active-low, with bit7=1.
REQ-026 The display SHALL keep showing the previous word_q during a read; word_q SHALL change only on ack or timeout.
REQ-027 Output latency SHALL be one cycle from idx or word_q change to sel/data change.

Reset
REQ-028 While rst=0: state=REQ, addr_q=0, word_q=0, err=0, mem_rd=0, mem_addr=0, divider=0, idx=0, sel=4'b1111, data=8'hFF.
REQ-029 Reset asserted mid-read SHALL drop mem_rd immediately (asynchronously); a late mem_ack after release SHALL be ignored unless in REQ.
REQ-030 The first REQ after reset release SHALL latch addr_a in the first clock edge.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, REQ, SHOW), the 16-entry seven-segment table, and the timeout-fill constant 16'hEEEE.
REQ-032 The hex decoder SHALL be one combinational sub-module, hex7seg (4-bit in, 7-bit active-low out).
REQ-033 RTL SHALL contain no latches and no clock gating.

Verification (SCAN_DIV=4, ACK_TIMEOUT=8)
REQ-034 Reset release, addr_a=0, memory acks after 2 cycles with 16'h1234 -> mem_rd high 2 cycles at mem_addr=0; then sel cycles 1110,1101,1011,0111 every 4 clocks; data=C0? no: data 8'h99,8'hB0,8'hA4,8'hF9 (digits 4,3,2,1).
REQ-035 addr_a changes 0->10 while in SHOW, memory returns 16'hABCD -> next REQ has mem_addr=10; word_q=16'hABCD; err=0.
REQ-036 Memory never acks -> mem_rd high exactly 8 cycles; every digit shows 8'h86 ("E"); err=1; the next frame retries.
REQ-037 mem_ack coincides with timeout cycle, data 16'h00FF -> word_q=16'h00FF, err=0.
REQ-038 addr_a changes during REQ -> current read completes with the old address; a second REQ follows with the new address.
REQ-039 rst pulled low mid-REQ -> mem_rd, sel and data reach reset values before the next clock edge.

Source files
------------

// File: rtl/mem_scan_ctrl_pkg.sv
// Shared types and constants for the memory-scan display controller:
// FSM state encoding, seven-segment table and the timeout fill word.
package mem_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SHOW = 2'd2
  } state_e;

  // Active-low segment patterns, bit order g..a, indexed by hex digit.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [15:0] TIMEOUT_FILL = 16'hEEEE;

endpackage

// File: rtl/mem_scan_ctrl_hex7seg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex7seg
  import mem_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/mem_scan_ctrl.sv
// Reads one 16-bit word from a memory at the user-selected address and shows
// it as four multiplexed hex digits, refreshing once per display frame.
module mem_scan_ctrl
  import mem_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr_a,
  output logic [3:0]  mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [3:0]  sel,
  output logic [7:0]  data,
  output logic        err
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT) + 1;

  state_e             state_q, state_d;
  logic               launch;
  logic               rd_q;
  logic [3:0]         addr_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               tmo_done;
  logic [15:0]        word_q;
  logic               err_q;

  logic [DIV_W-1:0]   div_q;
  logic [1:0]         idx_q;
  logic               div_wrap;
  logic               frame_end;
  logic [6:0]         seg;
  logic [3:0]         sel_q;
  logic [7:0]         data_q;

  assign div_wrap  = (div_q == DIV_W'(SCAN_DIV - 1));
  assign frame_end = div_wrap && (idx_q == 2'd3);
  assign tmo_done  = (tmo_q == TMO_W'(ACK_TIMEOUT - 1));

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    unique case (state_q)
      // The first REQ cycle after reset has no read in flight yet: it only
      // captures the address and raises the request.
      ST_REQ: begin
        if (!rd_q) begin
          launch = 1'b1;
        end else if (mem_ack || tmo_done) begin
          state_d = ST_SHOW;
        end
      end
      ST_SHOW, ST_IDLE: begin
        if ((addr_a != addr_q) || frame_end) begin
          state_d = ST_REQ;
          launch  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_REQ;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      tmo_q   <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        addr_q <= addr_a;
        rd_q   <= 1'b1;
        tmo_q  <= '0;
      end else if (rd_q) begin
        // An ack in the timeout cycle still wins and delivers real data.
        if (mem_ack) begin
          word_q <= mem_rdata;
          err_q  <= 1'b0;
          rd_q   <= 1'b0;
        end else if (tmo_done) begin
          word_q <= TIMEOUT_FILL;
          err_q  <= 1'b1;
          rd_q   <= 1'b0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end
    end
  end

  hex7seg u_hex7seg (
    .hex (word_q[{idx_q, 2'b00} +: 4]),
    .seg (seg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      idx_q  <= '0;
      sel_q  <= 4'hF;
      data_q <= 8'hFF;
    end else begin
      div_q <= div_wrap ? '0 : div_q + 1'b1;
      if (div_wrap) begin
        idx_q <= idx_q + 1'b1;
      end
      sel_q  <= ~(4'b0001 << idx_q);
      data_q <= {1'b1, seg};
    end
  end

  assign mem_addr = addr_q;
  assign mem_rd   = rd_q;
  assign err      = err_q;
  assign sel      = sel_q;
  assign data     = data_q;

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Randomized scoreboard bench for mem_scan_ctrl: a memory responder issues
// reads with chosen latencies, a monitor checks read outcome and the display.
module tb_mem_scan_ctrl;

  localparam int SD    = 4;
  localparam int T     = 8;
  localparam int FRAME = 4 * SD;

  localparam logic [7:0] SEG8 [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct {
    logic [15:0] word;
    logic        err;
    int          dur;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  addr_a;
  logic [3:0]  mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [3:0]  sel;
  logic [7:0]  data;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem [16];
  int          plan [$];
  exp_t        exp_q [$];

  // Shared bench model state
  logic [3:0]  addr_at_edge = '0;
  logic [15:0] word_model = '0;
  logic        err_model = 1'b0;
  logic [3:0]  exp_sel = 4'hF;
  logic [7:0]  exp_data = 8'hFF;
  logic        mon_rd_prev = 1'b0;

  mem_scan_ctrl #(
    .SCAN_DIV    (SD),
    .ACK_TIMEOUT (T)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr_a    (addr_a),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .sel       (sel),
    .data      (data),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Display model: idx follows the edge count since reset; outputs lag by one edge.
  int  n_edge = 0;
  logic rise_due = 1'b0;
  always @(posedge clk) begin
    int idx;
    if (!rst) begin
      n_edge   = 0;
      exp_sel  = 4'hF;
      exp_data = 8'hFF;
      rise_due = 1'b0;
    end else begin
      if (rise_due) check("frame_refresh_rd", mon_rd_prev, 1);
      rise_due = ((n_edge % FRAME) == FRAME - 1) && !mon_rd_prev;
      idx      = (n_edge / SD) % 4;
      exp_sel  = ~(4'b0001 << idx);
      exp_data = SEG8[int'((word_model >> (4 * idx)) & 16'hF)];
      addr_at_edge = addr_a;
      n_edge++;
    end
  end

  // Memory responder: picks a latency per read and records the expected outcome.
  int          lat = 0;
  int          resp_cnt = 0;
  logic        resp_rd_prev = 1'b0;
  logic [3:0]  exp_addr = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      mem_ack      = 1'b0;
      mem_rdata    = '0;
      resp_rd_prev = 1'b0;
      exp_q.delete();
    end else begin
      if (mem_rd && !resp_rd_prev) begin
        if (plan.size() > 0) lat = plan.pop_front();
        else if ($urandom_range(0, 9) < 3) lat = 0;
        else lat = $urandom_range(1, T);
        exp_addr = addr_at_edge;
        check("mem_addr_at_start", mem_addr, exp_addr);
        e.dur  = (lat == 0) ? T : lat;
        e.err  = (lat == 0);
        e.word = (lat == 0) ? 16'hEEEE : mem[exp_addr];
        exp_q.push_back(e);
        resp_cnt = 0;
      end
      if (mem_rd) begin
        resp_cnt++;
        if (resp_cnt > 1) check("mem_addr_hold", mem_addr, exp_addr);
        mem_ack   = (resp_cnt == lat);
        mem_rdata = mem_ack ? mem[mem_addr] : 16'($urandom);
      end else begin
        // Stray strobes while idle must have no effect.
        mem_ack   = ($urandom_range(0, 5) == 0);
        mem_rdata = 16'($urandom);
      end
      resp_rd_prev = mem_rd;
    end
  end

  // Monitor: pops the expectation when a read ends and checks all outputs.
  int         mon_cnt = 0;
  int         stale = 0;
  logic [3:0] mon_addr = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      mon_rd_prev = 1'b0;
      mon_cnt     = 0;
      stale       = 0;
      word_model  = '0;
      err_model   = 1'b0;
    end else begin
      if (!mem_rd && mon_rd_prev) begin
        if (exp_q.size() == 0) begin
          check("read_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("read_cycles", mon_cnt, e.dur);
          word_model = e.word;
          err_model  = e.err;
        end
      end
      if (mem_rd && !mon_rd_prev) begin
        mon_cnt  = 0;
        mon_addr = addr_at_edge;
      end
      if (mem_rd) begin
        mon_cnt++;
        if (mon_cnt == T + 1) check("rd_overrun", mon_cnt, T);
      end
      stale = (!mem_rd && (addr_a != mon_addr)) ? stale + 1 : 0;
      if (!mem_rd) check("addr_retrigger", (stale > 1), 0);
      check("sel", sel, exp_sel);
      check("data", data, exp_data);
      check("err", err, err_model);
      mon_rd_prev = mem_rd;
    end
  end

  task automatic wait_rd();
    for (int k = 0; k < 100 && !mem_rd; k++) @(negedge clk);
    check("rd_seen", mem_rd, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_rd"}, mem_rd, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_sel"}, sel, 4'hF);
    check({tag, "_data"}, data, 8'hFF);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic random_run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 11) == 0) begin
        #1 addr_a = 4'($urandom);
      end
    end
  endtask

  initial begin
    rst    = 1'b0;
    addr_a = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    mem[0]  = 16'h1234;
    mem[5]  = 16'h00FF;
    mem[10] = 16'hABCD;
    // Ack after 2, never, ack in the timeout cycle, then two normal reads.
    plan = '{2, 0, 8, 3, 8};

    repeat (3) @(negedge clk);
    check_reset_outputs("rst_init");
    #1 rst = 1'b1;

    repeat (50) @(negedge clk);
    #1 addr_a = 4'd10;
    repeat (30) @(negedge clk);
    #1 addr_a = 4'd5;
    repeat (30) @(negedge clk);

    // Address change while a read is in flight.
    wait_rd();
    #1 addr_a = 4'd3;
    repeat (30) @(negedge clk);

    random_run(1500);

    // Asynchronous reset in the middle of a read.
    wait_rd();
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_mid");
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;

    random_run(400);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
